jt1942_scrom_fetch: RTL and testbench

JT1942_SCROM_FETCH -- requirements
Module: jt1942_scrom_fetch

---
 rtl/jt1942_pkg.sv | 22 ++
 rtl/jt1942_scrom_fetch.sv | 197 +++++++++++++++++++
 tb/tb_jt1942_scrom_fetch.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt1942_pkg.sv
// ============================================================================
// jt1942_pkg
// ----------------------------------------------------------------------------
// Purpose : Definitions shared by the scroll-ROM fetch logic. Holds the fetch
//           state encoding and the number of bitplanes read per tile row.
// Contents:
//   scromState_t : fetch FSM states (IDLE=0, P0=1, P1=2, P2=3, DONE=4)
//   PLANE_COUNT  : bitplanes fetched per request (x, y, z)
// ============================================================================
package jt1942_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P0   = 3'd1,
        ST_P1   = 3'd2,
        ST_P2   = 3'd3,
        ST_DONE = 3'd4
    } scromState_t;

    localparam int PLANE_COUNT = 3;

endpackage

// File: rtl/jt1942_scrom_fetch.sv
// ============================================================================
// jt1942_scrom_fetch
// ----------------------------------------------------------------------------
// Purpose : Fetches the three bitplane bytes of a scroll tile row from an
//           8-bit ROM and presents them atomically as {z,y,x} to the scroll
//           stage. Plane k lives at scr_addr + k*PLANE_STEP.
// Ports   :
//   clk         in   24 MHz system clock
//   rst_n       in   synchronous active-low reset
//   cen6        in   6 MHz pixel enable (miss accounting only)
//   scr_addr    in   14-bit tile/row request address
//   scrom_data  out  24-bit packed {z,y,x} planes
//   data_ok     out  scrom_data belongs to the current scr_addr
//   rom_addr    out  ROM byte address (ROM_AW bits)
//   rom_cs      out  ROM read request
//   rom_data    in   ROM read data
//   rom_ok      in   ROM beat complete, rom_data valid
//   miss_cnt    out  saturating count of late fetches
// Config  : define JT1942_SCROM_MISS_EN to build the late-fetch counter;
//           otherwise miss_cnt is tied to zero.
// ============================================================================
module jt1942_scrom_fetch
    import jt1942_pkg::*;
#(
    parameter int unsigned       ROM_AW     = 16,
    parameter logic [ROM_AW-1:0] PLANE_STEP = 16'h4000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen6,
    input  logic [13:0]       scr_addr,
    output logic [23:0]       scrom_data,
    output logic              data_ok,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok,
    output logic [7:0]        miss_cnt
);

    scromState_t       r_state;
    scromState_t       w_nextState;
    logic [13:0]       r_lastAddr;
    logic [13:0]       r_heldAddr;
    logic              r_restart;
    logic              r_valid;
    logic              r_romCs;
    logic              w_nextCs;
    logic [ROM_AW-1:0] r_romAddr;
    logic [ROM_AW-1:0] w_nextAddr;
    logic [23:0]       r_scromData;
    logic [7:0]        r_planes [PLANE_COUNT];
    logic              w_changed;
    logic              w_beat;
    logic              w_start;
    logic              w_capture;
    logic              w_publish;
    logic              w_fetching;
    logic [1:0]        w_planeSel;
    logic [ROM_AW-1:0] w_scrAddrExt;

    assign w_scrAddrExt = ROM_AW'(scr_addr);
    assign w_changed    = (scr_addr != r_lastAddr);
    // A beat only counts while we are actually requesting.
    assign w_beat       = rom_ok & r_romCs;
    assign w_fetching   = (r_state == ST_P0) || (r_state == ST_P1) || (r_state == ST_P2);

    // Next-state logic. A request change seen during a plane fetch lets the
    // current beat finish, then drops back to IDLE so rom_cs gets a low cycle
    // before the restarted fetch; the pending restart flag forces that fetch
    // even if scr_addr has since returned to the old address.
    always_comb begin
        w_nextState = r_state;
        w_nextCs    = r_romCs;
        w_nextAddr  = r_romAddr;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_publish   = 1'b0;
        w_planeSel  = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_changed || r_restart) begin
                    w_start = 1'b1;
                end
            end
            ST_P0, ST_P1: begin
                w_planeSel = (r_state == ST_P0) ? 2'd0 : 2'd1;
                if (w_beat) begin
                    w_capture = 1'b1;
                    if (w_changed || r_restart) begin
                        w_nextState = ST_IDLE;
                        w_nextCs    = 1'b0;
                    end else begin
                        w_nextState = (r_state == ST_P0) ? ST_P1 : ST_P2;
                        w_nextAddr  = r_romAddr + PLANE_STEP;
                    end
                end
            end
            ST_P2: begin
                w_planeSel = 2'd2;
                if (w_beat) begin
                    w_capture   = 1'b1;
                    w_nextCs    = 1'b0;
                    w_nextState = (w_changed || r_restart) ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                w_publish   = 1'b1;
                w_nextState = ST_IDLE;
                if (w_changed) begin
                    w_start = 1'b1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextCs    = 1'b0;
            end
        endcase
        // rom_cs is low in both IDLE and DONE, so starting from either keeps
        // the mandatory gap between fetches.
        if (w_start) begin
            w_nextState = ST_P0;
            w_nextCs    = 1'b1;
            w_nextAddr  = w_scrAddrExt;
        end
    end

    // State, ROM request and data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_romCs     <= 1'b0;
            r_romAddr   <= '0;
            r_lastAddr  <= '0;
            r_heldAddr  <= '0;
            r_restart   <= 1'b0;
            r_valid     <= 1'b0;
            r_scromData <= '0;
            for (int i = 0; i < PLANE_COUNT; i++) begin
                r_planes[i] <= '0;
            end
        end else begin
            r_state   <= w_nextState;
            r_romCs   <= w_nextCs;
            r_romAddr <= w_nextAddr;
            if (w_start) begin
                r_lastAddr <= scr_addr;
                r_restart  <= 1'b0;
            end else if (w_fetching && w_changed) begin
                r_restart <= 1'b1;
            end
            if (w_capture) begin
                r_planes[w_planeSel] <= rom_data;
            end
            if (w_publish) begin
                r_scromData <= {r_planes[2], r_planes[1], r_planes[0]};
                r_heldAddr  <= r_lastAddr;
                r_valid     <= 1'b1;
            end
        end
    end

    assign scrom_data = r_scromData;
    assign data_ok    = r_valid && (scr_addr == r_heldAddr);
    assign rom_cs     = r_romCs;
    assign rom_addr   = r_romAddr;

`ifdef JT1942_SCROM_MISS_EN
    logic [7:0] r_missCnt;
    logic [7:0] r_cenSince;

    // Counts pixel enables since the fetch started; every enable after the
    // eighth with the fetch still outstanding is one late pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_missCnt  <= '0;
            r_cenSince <= '0;
        end else if (w_start) begin
            r_cenSince <= '0;
        end else if (cen6 && w_fetching) begin
            if (r_cenSince != 8'hFF) begin
                r_cenSince <= r_cenSince + 8'd1;
            end
            if ((r_cenSince >= 8'd8) && (r_missCnt != 8'hFF)) begin
                r_missCnt <= r_missCnt + 8'd1;
            end
        end
    end

    assign miss_cnt = r_missCnt;
`else
    logic w_unusedCen;
    assign w_unusedCen = cen6;
    assign miss_cnt    = 8'h00;
`endif

endmodule

// File: tb/tb_jt1942_scrom_fetch.sv
// ============================================================================
// tb_jt1942_scrom_fetch
// ----------------------------------------------------------------------------
// Directed bench for jt1942_scrom_fetch. Two instances: the default one
// (PLANE_STEP 0x4000) and a wide-step one (PLANE_STEP 0xC001) for address
// wrap. Each has a ROM that answers addr[7:0] after a 2-clk beat.
// ============================================================================
module tb_jt1942_scrom_fetch;

    logic        clk;
    logic        rstN;
    logic        cen6;
    logic [13:0] scrAddr,  scrAddrW;
    logic [23:0] scromData, scromDataW;
    logic        dataOk,   dataOkW;
    logic [15:0] romAddr,  romAddrW;
    logic        romCs,    romCsW;
    logic [7:0]  romData,  romDataW;
    logic        romOk,    romOkW;
    logic [7:0]  missCnt,  missCntW;
    logic        romStuck;

    logic [15:0] beatLog  [$];
    logic [15:0] beatLogW [$];

    int checks = 0;
    int errors = 0;

`ifdef JT1942_SCROM_MISS_EN
    localparam int EXP_MISS = 32;
`else
    localparam int EXP_MISS = 0;
`endif

    jt1942_scrom_fetch dut (
        .clk(clk), .rst_n(rstN), .cen6(cen6), .scr_addr(scrAddr),
        .scrom_data(scromData), .data_ok(dataOk), .rom_addr(romAddr),
        .rom_cs(romCs), .rom_data(romData), .rom_ok(romOk), .miss_cnt(missCnt)
    );

    jt1942_scrom_fetch #(.ROM_AW(16), .PLANE_STEP(16'hC001)) dutW (
        .clk(clk), .rst_n(rstN), .cen6(cen6), .scr_addr(scrAddrW),
        .scrom_data(scromDataW), .data_ok(dataOkW), .rom_addr(romAddrW),
        .rom_cs(romCsW), .rom_data(romDataW), .rom_ok(romOkW), .miss_cnt(missCntW)
    );

    // Expected packed planes for a request: each ROM byte is the low byte of
    // its own address, planes are step apart, arithmetic wraps at 16 bits.
    function automatic logic [23:0] expTriple(input logic [13:0] a, input logic [15:0] step);
        logic [15:0] b0, b1, b2;
        b0 = {2'b00, a};
        b1 = b0 + step;
        b2 = b1 + step;
        return {b2[7:0], b1[7:0], b0[7:0]};
    endfunction

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // One-in-four pixel enable.
    initial begin
        int div;
        div  = 0;
        cen6 = 1'b0;
        forever begin
            @(negedge clk);
            div  = div + 1;
            cen6 = (div % 4 == 0);
        end
    end

    // ROM for the default instance: 2-clk beats, can be stalled.
    initial begin
        int busy;
        busy = 0; romOk = 1'b0; romData = 8'h00;
        forever begin
            @(negedge clk);
            if (romCs === 1'b1 && !romStuck && rstN) begin
                if (busy == 1) begin
                    romOk = 1'b1; romData = romAddr[7:0];
                    beatLog.push_back(romAddr); busy = 0;
                end else begin
                    romOk = 1'b0; busy = 1;
                end
            end else begin
                romOk = 1'b0; busy = 0;
            end
        end
    end

    // ROM for the wide-step instance.
    initial begin
        int busy;
        busy = 0; romOkW = 1'b0; romDataW = 8'h00;
        forever begin
            @(negedge clk);
            if (romCsW === 1'b1 && rstN) begin
                if (busy == 1) begin
                    romOkW = 1'b1; romDataW = romAddrW[7:0];
                    beatLogW.push_back(romAddrW); busy = 0;
                end else begin
                    romOkW = 1'b0; busy = 1;
                end
            end else begin
                romOkW = 1'b0; busy = 0;
            end
        end
    end

    // Continuous model compare: valid data must match the current request,
    // and an unfinished beat must keep its request and address.
    initial begin
        logic        prevCs, prevCsW;
        logic [15:0] prevAddr, prevAddrW;
        prevCs = 1'b0; prevCsW = 1'b0; prevAddr = '0; prevAddrW = '0;
        forever begin
            @(posedge clk); #5;
            if (rstN === 1'b1) begin
                if (dataOk === 1'b1) begin
                    checks++;
                    if (scromData !== expTriple(scrAddr, 16'h4000)) begin
                        errors++;
                        $display("[TB] FAIL modelTriple got %h expected %h", scromData, expTriple(scrAddr, 16'h4000));
                    end
                end
                if (dataOkW === 1'b1) begin
                    checks++;
                    if (scromDataW !== expTriple(scrAddrW, 16'hC001)) begin
                        errors++;
                        $display("[TB] FAIL modelTripleW got %h expected %h", scromDataW, expTriple(scrAddrW, 16'hC001));
                    end
                end
                if (prevCs === 1'b1 && romOk === 1'b0) begin
                    checks++;
                    if (romCs !== 1'b1 || romAddr !== prevAddr) begin
                        errors++;
                        $display("[TB] FAIL beatHold got cs=%b addr=%h expected cs=1 addr=%h", romCs, romAddr, prevAddr);
                    end
                end
                if (prevCsW === 1'b1 && romOkW === 1'b0) begin
                    checks++;
                    if (romCsW !== 1'b1 || romAddrW !== prevAddrW) begin
                        errors++;
                        $display("[TB] FAIL beatHoldW got cs=%b addr=%h expected cs=1 addr=%h", romCsW, romAddrW, prevAddrW);
                    end
                end
            end
            prevCs = romCs; prevAddr = romAddr; prevCsW = romCsW; prevAddrW = romAddrW;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [13:0] a);
        @(negedge clk);
        scrAddr = a;
    endtask

    task automatic waitDataOk(input int which, input int maxCycles, input string name);
        int  n;
        bit  seen;
        n = 0; seen = 1'b0;
        while (n < maxCycles && !seen) begin
            @(posedge clk); #5;
            n++;
            seen = (which == 0) ? (dataOk === 1'b1) : (dataOkW === 1'b1);
        end
        checkOutput(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic waitBeats(input int count, input int maxCycles, input string name);
        int n;
        n = 0;
        while (n < maxCycles && beatLog.size() < count) begin
            @(posedge clk); #5;
            n++;
        end
        checkOutput(name, beatLog.size(), count);
    endtask

    task automatic checkLog(input string name, input int which, input int n,
                            input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                            input logic [15:0] e3, input logic [15:0] e4);
        logic [15:0] exp [5];
        logic [15:0] got;
        int          sz;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3; exp[4] = e4;
        sz = (which == 0) ? beatLog.size() : beatLogW.size();
        checkOutput({name, "Count"}, sz, n);
        for (int i = 0; i < n; i++) begin
            got = 16'hFFFF;
            if (i < sz) got = (which == 0) ? beatLog[i] : beatLogW[i];
            checkOutput($sformatf("%s[%0d]", name, i), {16'd0, got}, {16'd0, exp[i]});
        end
    endtask

    initial begin
        bit partialSeen;
        int pulses;
        int n;
        rstN = 1'b0; scrAddr = '0; scrAddrW = '0; romStuck = 1'b0;
        repeat (3) @(posedge clk);
        #5;
        checkOutput("resetRomCs",   {31'd0, romCs}, 32'd0);
        checkOutput("resetRomAddr", {16'd0, romAddr}, 32'd0);
        checkOutput("resetScrom",   {8'd0, scromData}, 32'd0);
        checkOutput("resetDataOk",  {31'd0, dataOk}, 32'd0);
        checkOutput("resetMiss",    {24'd0, missCnt}, 32'd0);
        @(negedge clk); rstN = 1'b1;
        repeat (3) @(posedge clk);
        #5;
        checkOutput("idleZeroAddrCs", {31'd0, romCs}, 32'd0);

        // Plain fetch.
        beatLog.delete();
        applyStimulus(14'h0123);
        waitDataOk(0, 60, "fetch0123Done");
        checkLog("beats0123", 0, 3, 16'h0123, 16'h4123, 16'h8123, 16'h0, 16'h0);
        checkOutput("scrom0123", {8'd0, scromData}, 32'h00232323);

        // Request change while plane 1 is being read.
        beatLog.delete();
        applyStimulus(14'h0010);
        waitBeats(1, 40, "plane0Beat");
        applyStimulus(14'h0020);
        partialSeen = 1'b0;
        n = 0;
        while (n < 80 && dataOk !== 1'b1) begin
            @(posedge clk); #5;
            n++;
            if (scromData !== 24'h232323 && scromData !== 24'h202020) partialSeen = 1'b1;
        end
        checkOutput("restartDone", {31'd0, dataOk}, 32'd1);
        checkOutput("noStaleUpdate", {31'd0, partialSeen}, 32'd0);
        checkLog("beatsRestart", 0, 5, 16'h0010, 16'h4010, 16'h0020, 16'h4020, 16'h8020);
        checkOutput("scrom0020", {8'd0, scromData}, 32'h00202020);

        // Request change landing on the DONE cycle.
        beatLog.delete();
        applyStimulus(14'h0031);
        waitBeats(3, 60, "doneBeats");
        scrAddr = 14'h0042;
        @(posedge clk); #5;
        checkOutput("doneUpdateKept", {8'd0, scromData}, 32'h00313131);
        checkOutput("doneRestartCs",  {31'd0, romCs}, 32'd1);
        checkOutput("doneRestartAddr", {16'd0, romAddr}, 32'h00000042);
        checkOutput("doneDataOkLow",  {31'd0, dataOk}, 32'd0);
        waitDataOk(0, 60, "fetch0042Done");
        checkOutput("scrom0042", {8'd0, scromData}, 32'h00424242);

        // Address wrap with a wide plane step.
        beatLogW.delete();
        @(negedge clk); scrAddrW = 14'h3FFF;
        waitDataOk(1, 60, "wrapDone");
        checkLog("beatsWrap", 1, 3, 16'h3FFF, 16'h0000, 16'hC001, 16'h0, 16'h0);
        checkOutput("scromWrap", {8'd0, scromDataW}, 32'h000100FF);

        // Stalled ROM for 40 pixel enables.
        romStuck = 1'b1;
        applyStimulus(14'h0100);
        @(posedge clk);
        pulses = 0; n = 0;
        while (pulses < 40 && n < 400) begin
            @(posedge clk); #5;
            n++;
            if (cen6) pulses++;
        end
        checkOutput("missPulses", pulses, 40);
        checkOutput("missCount", {24'd0, missCnt}, EXP_MISS);
        romStuck = 1'b0;
        waitDataOk(0, 60, "fetch0100Done");
        checkOutput("scrom0100", {8'd0, scromData}, 32'h00000000);

        // Reset in the middle of the plane-2 beat.
        beatLog.delete();
        applyStimulus(14'h0055);
        waitBeats(2, 40, "p2Reached");
        romStuck = 1'b1;
        @(negedge clk); @(negedge clk);
        rstN = 1'b0;
        @(posedge clk); #5;
        checkOutput("midResetCs",    {31'd0, romCs}, 32'd0);
        checkOutput("midResetScrom", {8'd0, scromData}, 32'd0);
        checkOutput("midResetOk",    {31'd0, dataOk}, 32'd0);
        checkOutput("midResetState", 32'(dut.r_state), 32'd0);
        checkOutput("midResetMiss",  {24'd0, missCnt}, 32'd0);
        @(negedge clk);
        scrAddr = 14'h0077; romStuck = 1'b0; rstN = 1'b1;
        @(posedge clk); #5;
        checkOutput("releaseStartCs",   {31'd0, romCs}, 32'd1);
        checkOutput("releaseStartAddr", {16'd0, romAddr}, 32'h00000077);
        waitDataOk(0, 60, "fetch0077Done");
        checkOutput("scrom0077", {8'd0, scromData}, 32'h00777777);

        // Steady request: no further ROM traffic, data stays valid.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #5;
            checkOutput("holdCs", {31'd0, romCs}, 32'd0);
            checkOutput("holdOk", {31'd0, dataOk}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
